// File: rtl/conv_pkg.sv
// conv_pkg: shared dimensions, loader state encoding and stream-index decode for the conv tile loader.
package conv_pkg;
  localparam int TILE_DIM    = 6;
  localparam int KER_DIM     = 3;
  localparam int OUT_DIM     = 4;
  localparam int KER_BYTES   = 9;
  localparam int FRAME_BYTES = 45;
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} loader_state_t;
  typedef logic [7:0] byte_t;
  typedef struct packed {
    logic       ker;
    logic [2:0] row;
    logic [2:0] col;
  } rc_t;
  // Stream index 0..8 lands in the kernel, 9..44 in the tile, both row-major.
  function automatic rc_t decode(input logic [5:0] k);
    rc_t        r;
    logic [5:0] t;
    t     = k - 6'(KER_BYTES);
    r.ker = k < 6'(KER_BYTES);
    r.row = r.ker ? 3'(k / 6'(KER_DIM)) : 3'(t / 6'(TILE_DIM));
    r.col = r.ker ? 3'(k % 6'(KER_DIM)) : 3'(t % 6'(TILE_DIM));
    return r;
  endfunction
endpackage

// File: rtl/conv_tile_loader.sv
// conv_tile_loader: assembles a kernel+tile byte stream into held arrays and hands them to the conv engine.
// CONV_TILE_LOADER_KERNEL_HOLD_EN adds kernel_hold, letting a frame carry only the 36 tile bytes.
module conv_tile_loader
  import conv_pkg::*;
#(
  parameter int DONE_TIMEOUT = 40
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [7:0]                                 in_data,
  input  logic                                       in_valid,
  input  logic                                       in_last,
  output logic                                       in_ready,
  output logic [TILE_DIM-1:0][TILE_DIM-1:0][7:0]     input_tile,
  output logic [KER_DIM-1:0][KER_DIM-1:0][7:0]       kernel,
  output logic                                       conv_start,
  input  logic                                       conv_done,
  output logic                                       busy,
  output logic                                       err_frame
`ifdef CONV_TILE_LOADER_KERNEL_HOLD_EN
  ,
  input  logic                                       kernel_hold
`endif
);
  localparam int TW = $clog2(DONE_TIMEOUT);
  localparam logic [5:0] LAST_IDX = 6'(FRAME_BYTES - 1);
  loader_state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d, k;
  logic busy_q, busy_d, err_q, err_d, done_q, done_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [KER_DIM-1:0][KER_DIM-1:0][7:0] ker_q, ker_d;
  logic [TILE_DIM-1:0][TILE_DIM-1:0][7:0] tile_q, tile_d;
  logic xfer, wait_exit;
  rc_t rc;
`ifdef CONV_TILE_LOADER_KERNEL_HOLD_EN
  assign k = (state_q == IDLE && kernel_hold) ? 6'(KER_BYTES) : cnt_q;
`else
  assign k = cnt_q;
`endif
  assign rc         = decode(k);
  assign in_ready   = ~rst & (state_q == IDLE || state_q == LOAD);
  assign conv_start = ~rst & (state_q == START);
  assign xfer       = in_valid & in_ready;
  // A sticky-high conv_done gives no edge, so the timer is the fallback exit.
  assign wait_exit  = (conv_done & ~done_q) | (timer_q == TW'(DONE_TIMEOUT - 1));
  assign input_tile = tile_q;
  assign kernel     = ker_q;
  assign busy       = busy_q;
  assign err_frame  = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = done_q;
    timer_d = timer_q;
    ker_d   = ker_q;
    tile_d  = tile_q;
    if (xfer) begin
      if (rc.ker) ker_d[2'(rc.row)][2'(rc.col)] = in_data;
      else tile_d[rc.row][rc.col] = in_data;
      busy_d = 1'b1;
      if (k == LAST_IDX) begin
        state_d = START;
        cnt_d   = LAST_IDX;
        err_d   = err_q | ~in_last;
      end else if (in_last) begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        err_d   = 1'b1;
      end else begin
        state_d = LOAD;
        cnt_d   = k + 6'd1;
      end
    end else if (state_q == START) begin
      state_d = WAIT;
      timer_d = '0;
      done_d  = conv_done;
    end else if (state_q == WAIT) begin
      timer_d = timer_q + TW'(1);
      done_d  = conv_done;
      if (wait_exit) begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      timer_q <= '0;
      ker_q   <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      done_q  <= done_d;
      timer_q <= timer_d;
      ker_q   <= ker_d;
      tile_q  <= tile_d;
    end
  end
endmodule

// File: tb/tb_conv_tile_loader.sv
// tb_conv_tile_loader: directed self-checking bench for conv_tile_loader.
module tb_conv_tile_loader;
  logic clk = 1'b0;
  logic rst, in_valid, in_last, in_ready, conv_start, conv_done, busy, err_frame;
  logic [7:0] in_data;
  logic [5:0][5:0][7:0] input_tile;
  logic [2:0][2:0][7:0] kernel;
`ifdef CONV_TILE_LOADER_KERNEL_HOLD_EN
  logic kernel_hold = 1'b0;
`endif
  int total = 0;
  int passed = 0;
  int starts = 0;
  int s0;
  always #5 clk = ~clk;
  always @(posedge clk) if (conv_start) starts <= starts + 1;
  conv_tile_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .input_tile(input_tile), .kernel(kernel), .conv_start(conv_start),
    .conv_done(conv_done), .busy(busy), .err_frame(err_frame)
`ifdef CONV_TILE_LOADER_KERNEL_HOLD_EN
    , .kernel_hold(kernel_hold)
`endif
  );
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] base, input int n, input bit last);
    bit ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data  = base + 8'(i);
      in_valid = 1'b1;
      in_last  = last && (i == n - 1);
      if (in_ready !== 1'b1) ok = 1'b0;
      step(1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++;
    if (!ok) $display("FAIL send_frame in_ready dropped while loading (base %0d)", base);
    else passed++;
  endtask
  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; conv_done = 1'b0;
    step(2);
    total++;
    if ({in_ready, conv_start, busy, err_frame} !== 4'b0000) $display("FAIL reset_outs got %b exp 0000", {in_ready, conv_start, busy, err_frame});
    else passed++;
    total++;
    if (kernel !== '0 || input_tile !== '0) $display("FAIL reset_arrays got k00=%0h t55=%0h exp 0", kernel[0][0], input_tile[5][5]);
    else passed++;
    rst = 1'b0;
    step(1);
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", in_ready);
    else passed++;
  endtask
  task automatic test_load;
    send_frame(8'd1, 45, 1'b1);
    total++;
    if (conv_start !== 1'b1) $display("FAIL load_start got %b exp 1", conv_start);
    else passed++;
    total++;
    if (kernel[0][0] !== 8'd1 || kernel[2][2] !== 8'd9 || kernel[1][0] !== 8'd4) $display("FAIL load_kernel got %0d %0d %0d exp 1 9 4", kernel[0][0], kernel[2][2], kernel[1][0]);
    else passed++;
    total++;
    if (input_tile[0][0] !== 8'd10 || input_tile[5][5] !== 8'd45 || input_tile[1][0] !== 8'd16) $display("FAIL load_tile got %0d %0d %0d exp 10 45 16", input_tile[0][0], input_tile[5][5], input_tile[1][0]);
    else passed++;
    step(1);
    total++;
    if ({conv_start, busy, in_ready} !== 3'b010) $display("FAIL load_wait got %b exp 010", {conv_start, busy, in_ready});
    else passed++;
  endtask
  task automatic test_done_edge;
    step(36);
    conv_done = 1'b1;
    total++;
    if ({busy, in_ready} !== 2'b10) $display("FAIL done_before got %b exp 10", {busy, in_ready});
    else passed++;
    step(1);
    total++;
    if ({busy, in_ready} !== 2'b01) $display("FAIL done_exit got %b exp 01", {busy, in_ready});
    else passed++;
  endtask
  task automatic test_timeout;
    send_frame(8'd1, 45, 1'b1);
    step(40);
    total++;
    if ({busy, in_ready} !== 2'b10) $display("FAIL timeout_early got %b exp 10", {busy, in_ready});
    else passed++;
    step(1);
    total++;
    if ({busy, in_ready} !== 2'b01) $display("FAIL timeout_exit got %b exp 01", {busy, in_ready});
    else passed++;
    conv_done = 1'b0;
  endtask
  task automatic test_early_last;
    s0 = starts;
    send_frame(8'd60, 20, 1'b1);
    total++;
    if ({err_frame, busy, in_ready, conv_start} !== 4'b1010) $display("FAIL early_last_flags got %b exp 1010", {err_frame, busy, in_ready, conv_start});
    else passed++;
    total++;
    if (input_tile[1][4] !== 8'd79) $display("FAIL early_last_byte got %0d exp 79", input_tile[1][4]);
    else passed++;
    step(3);
    total++;
    if (starts !== s0) $display("FAIL early_last_nostart got %0d exp %0d", starts, s0);
    else passed++;
    send_frame(8'd100, 45, 1'b1);
    total++;
    if (conv_start !== 1'b1 || kernel[1][1] !== 8'd104 || input_tile[0][0] !== 8'd109 || input_tile[5][5] !== 8'd144) $display("FAIL early_last_reload got st=%b %0d %0d %0d exp 1 104 109 144", conv_start, kernel[1][1], input_tile[0][0], input_tile[5][5]);
    else passed++;
    total++;
    if (err_frame !== 1'b1) $display("FAIL err_sticky got %b exp 1", err_frame);
    else passed++;
    step(1);
    conv_done = 1'b1;
    step(1);
    conv_done = 1'b0;
    total++;
    if (in_ready !== 1'b1) $display("FAIL early_last_done got %b exp 1", in_ready);
    else passed++;
  endtask
  task automatic test_back_to_back;
    bit blocked = 1'b1;
    send_frame(8'd200, 45, 1'b1);
    in_data = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (in_ready !== 1'b0) blocked = 1'b0;
    end
    total++;
    if (!blocked) $display("FAIL wait_ready got 1 exp 0");
    else passed++;
    total++;
    if (kernel[0][0] !== 8'd200 || input_tile[5][5] !== 8'd244) $display("FAIL wait_frozen got %0d %0d exp 200 244", kernel[0][0], input_tile[5][5]);
    else passed++;
    conv_done = 1'b1;
    step(1);
    conv_done = 1'b0;
    total++;
    if (in_ready !== 1'b1) $display("FAIL wait_exit_ready got %b exp 1", in_ready);
    else passed++;
    step(1);
    in_valid = 1'b0;
    total++;
    if (kernel[0][0] !== 8'hFF || busy !== 1'b1) $display("FAIL post_wait_accept got %0h busy=%b exp ff 1", kernel[0][0], busy);
    else passed++;
  endtask
  task automatic test_mid_reset;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    send_frame(8'd1, 30, 1'b0);
    total++;
    if (busy !== 1'b1 || input_tile[3][2] !== 8'd30) $display("FAIL partial_load got busy=%b %0d exp 1 30", busy, input_tile[3][2]);
    else passed++;
    s0 = starts;
    rst = 1'b1;
    step(1);
    total++;
    if ({in_ready, conv_start, busy, err_frame} !== 4'b0000 || kernel[0][0] !== 8'd0 || input_tile[3][2] !== 8'd0) $display("FAIL rst_load got %b %0d %0d exp 0000 0 0", {in_ready, conv_start, busy, err_frame}, kernel[0][0], input_tile[3][2]);
    else passed++;
    rst = 1'b0;
    step(1);
    send_frame(8'd1, 45, 1'b1);
    step(3);
    rst = 1'b1;
    step(1);
    total++;
    if ({conv_start, busy} !== 2'b00 || input_tile[5][5] !== 8'd0) $display("FAIL rst_wait got %b %0d exp 00 0", {conv_start, busy}, input_tile[5][5]);
    else passed++;
    rst = 1'b0;
    step(45);
    total++;
    if (starts !== s0 + 1 || in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rst_nostray got starts=%0d rdy=%b busy=%b exp %0d 1 0", starts, in_ready, busy, s0 + 1);
    else passed++;
  endtask
  task automatic test_no_last;
    send_frame(8'd10, 45, 1'b0);
    total++;
    if ({err_frame, conv_start} !== 2'b11 || input_tile[5][5] !== 8'd54) $display("FAIL no_last got %b %0d exp 11 54", {err_frame, conv_start}, input_tile[5][5]);
    else passed++;
    step(1);
    conv_done = 1'b1;
    step(1);
    conv_done = 1'b0;
  endtask
`ifdef CONV_TILE_LOADER_KERNEL_HOLD_EN
  task automatic test_kernel_hold;
    send_frame(8'd1, 45, 1'b1);
    step(1);
    conv_done = 1'b1;
    step(1);
    conv_done = 1'b0;
    kernel_hold = 1'b1;
    send_frame(8'd50, 36, 1'b1);
    kernel_hold = 1'b0;
    total++;
    if (conv_start !== 1'b1 || kernel[2][2] !== 8'd9 || kernel[0][0] !== 8'd1) $display("FAIL hold_kernel got st=%b %0d %0d exp 1 9 1", conv_start, kernel[2][2], kernel[0][0]);
    else passed++;
    total++;
    if (input_tile[0][0] !== 8'd50 || input_tile[5][5] !== 8'd85) $display("FAIL hold_tile got %0d %0d exp 50 85", input_tile[0][0], input_tile[5][5]);
    else passed++;
    step(1);
    conv_done = 1'b1;
    step(1);
    conv_done = 1'b0;
  endtask
`endif
  initial begin
    test_reset();
    test_load();
    test_done_edge();
    test_timeout();
    test_early_last();
    test_back_to_back();
    test_mid_reset();
    test_no_last();
`ifdef CONV_TILE_LOADER_KERNEL_HOLD_EN
    test_kernel_hold();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
